// File: rtl/uart_rx_ctrl_if.sv
// Link between uart_rx_ctrl and its neighbours: launch/status from the receiver,
// and the show-ahead FIFO read port toward the host.
interface uart_rx_ctrl_if #(
  parameter int data_wd    = 8,
  parameter int fifo_depth = 4
);
  logic                        rx_start;
  logic                        rx_done;
  logic                        rx_busy;
  logic                        parity_error_flag;
  logic                        framing_error_flag;
  logic [data_wd-1:0]          dout;
  logic                        rd_en;
  logic [data_wd-1:0]          rd_data;
  logic                        rd_valid;
  logic [$clog2(fifo_depth):0] fifo_count;

  modport master (
    output rx_start, rd_data, rd_valid, fifo_count,
    input  rx_done, rx_busy, parity_error_flag, framing_error_flag, dout, rd_en
  );

  modport slave (
    input  rx_start, rd_data, rd_valid, fifo_count,
    output rx_done, rx_busy, parity_error_flag, framing_error_flag, dout, rd_en
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// Receive sequencer for uart_rx: start-edge launch, frame buffering in a
// show-ahead FIFO, and saturating framing/parity/timeout event counters.
module uart_rx_ctrl #(
  parameter int data_wd           = 8,
  parameter int oversampling_rate = 16,
  parameter int fifo_depth        = 4,
  parameter int timeout_ticks     = 256
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rx,
  input  logic           tick,
  input  logic           enable,
  input  logic           clr_status,
  output logic           overrun,
  output logic [7:0]     frame_err_cnt,
  output logic [7:0]     parity_err_cnt,
  output logic [7:0]     timeout_cnt,
  uart_rx_ctrl_if.master bus
);

  localparam int ptr_w = $clog2(fifo_depth);
  localparam int cnt_w = $clog2(timeout_ticks + 1);
  localparam logic [cnt_w-1:0] tmo_lim   = cnt_w'(timeout_ticks);
  localparam logic [cnt_w-1:0] osr_lim   = cnt_w'(oversampling_rate);
  localparam logic [ptr_w:0]   fifo_full = (ptr_w + 1)'(fifo_depth);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_START = 3'd1,
    LAUNCH     = 3'd2,
    RECV       = 3'd3,
    RECOVER    = 3'd4
  } state_t;

  state_t state_r, next_state_s;

  logic sync1_r, rx_s, rx_q;
  logic done_d_r, ferr_d_r, perr_d_r;
  logic done_rise_r, ferr_rise_r, perr_rise_r;
  logic [data_wd-1:0] dout_r;
  logic start_edge_s;
  logic [cnt_w-1:0] cnt_r;
  logic rx_start_r;
  logic push_s, inc_ferr_s, inc_perr_s, inc_tmo_s;

  logic [data_wd-1:0] mem_r [fifo_depth];
  logic [ptr_w-1:0]   wr_ptr_r, rd_ptr_r;
  logic [ptr_w:0]     count_r;
  logic               full_s, pop_s, wr_ok_s;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign start_edge_s = rx_q & ~rx_s;

  // Line synchronizer plus registered rising edges of the receiver status.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r     <= 1'b1;
      rx_s        <= 1'b1;
      rx_q        <= 1'b1;
      done_d_r    <= 1'b0;
      ferr_d_r    <= 1'b0;
      perr_d_r    <= 1'b0;
      done_rise_r <= 1'b0;
      ferr_rise_r <= 1'b0;
      perr_rise_r <= 1'b0;
      dout_r      <= '0;
    end else begin
      sync1_r     <= rx;
      rx_s        <= sync1_r;
      rx_q        <= rx_s;
      done_d_r    <= bus.rx_done;
      ferr_d_r    <= bus.framing_error_flag;
      perr_d_r    <= bus.parity_error_flag;
      done_rise_r <= bus.rx_done & ~done_d_r;
      ferr_rise_r <= bus.framing_error_flag & ~ferr_d_r;
      perr_rise_r <= bus.parity_error_flag & ~perr_d_r;
      dout_r      <= bus.rx_done ? bus.dout : dout_r;
    end
  end

  // State register; rx_start is registered so it is high exactly in LAUNCH.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      rx_start_r <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      rx_start_r <= (next_state_s == LAUNCH);
    end
  end

  // Next-state and event decode.
  always_comb begin
    next_state_s = state_r;
    push_s       = 1'b0;
    inc_ferr_s   = 1'b0;
    inc_perr_s   = 1'b0;
    inc_tmo_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (enable) next_state_s = WAIT_START;
        else        next_state_s = IDLE;
      end
      WAIT_START: begin
        if (!enable)          next_state_s = IDLE;
        else if (start_edge_s) next_state_s = LAUNCH;
        else                  next_state_s = WAIT_START;
      end
      LAUNCH: next_state_s = RECV;
      RECV: begin
        if (done_rise_r) begin
          push_s       = 1'b1;
          next_state_s = enable ? WAIT_START : IDLE;
        end else if (ferr_rise_r) begin
          inc_ferr_s   = 1'b1;
          next_state_s = RECOVER;
        end else if (perr_rise_r) begin
          inc_perr_s   = 1'b1;
          next_state_s = RECOVER;
        end else if (cnt_r >= tmo_lim) begin
          inc_tmo_s    = 1'b1;
          next_state_s = RECOVER;
        end else begin
          next_state_s = RECV;
        end
      end
      RECOVER: begin
        if (rx_s && (cnt_r >= osr_lim)) next_state_s = enable ? WAIT_START : IDLE;
        else                            next_state_s = RECOVER;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Shared tick counter: timeout in RECV, idle-line qualification in RECOVER.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (next_state_s != state_r) begin
      cnt_r <= '0;
    end else if (state_r == RECV) begin
      cnt_r <= tick ? cnt_r + {{(cnt_w-1){1'b0}}, 1'b1} : cnt_r;
    end else if (state_r == RECOVER) begin
      if (!rx_s)     cnt_r <= '0;
      else if (tick) cnt_r <= cnt_r + {{(cnt_w-1){1'b0}}, 1'b1};
      else           cnt_r <= cnt_r;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign full_s  = (count_r == fifo_full);
  assign pop_s   = bus.rd_en & (count_r != '0);
  assign wr_ok_s = push_s & (~full_s | pop_s);

  // Circular FIFO storage and pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < fifo_depth; i++) mem_r[i] <= '0;
    end else begin
      if (wr_ok_s) begin
        mem_r[wr_ptr_r] <= dout_r;
        wr_ptr_r        <= wr_ptr_r + {{(ptr_w-1){1'b0}}, 1'b1};
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + {{(ptr_w-1){1'b0}}, 1'b1};
      case ({wr_ok_s, pop_s})
        2'b10:   count_r <= count_r + {{ptr_w{1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{ptr_w{1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky overrun and saturating event counters; clearing wins over increments.
  always_ff @(posedge clk) begin
    if (rst || clr_status) begin
      overrun        <= 1'b0;
      frame_err_cnt  <= 8'd0;
      parity_err_cnt <= 8'd0;
      timeout_cnt    <= 8'd0;
    end else begin
      overrun        <= overrun | (push_s & full_s & ~pop_s);
      frame_err_cnt  <= inc_ferr_s ? sat_inc(frame_err_cnt)  : frame_err_cnt;
      parity_err_cnt <= inc_perr_s ? sat_inc(parity_err_cnt) : parity_err_cnt;
      timeout_cnt    <= inc_tmo_s  ? sat_inc(timeout_cnt)    : timeout_cnt;
    end
  end

  assign bus.rx_start   = rx_start_r;
  assign bus.rd_data    = mem_r[rd_ptr_r];
  assign bus.rd_valid   = (count_r != '0);
  assign bus.fifo_count = count_r;

endmodule
